xilinx_tdp_bram_array: RTL and testbench

//  True-dual-port BRAM array tiled in both width and depth: DEPTH words of DATA_WIDTH bits built from

---
 rtl/xilinx_primitive_pkg.sv | 34 +++
 rtl/xilinx_tdp_bram.sv | 104 ++++++++++
 rtl/xilinx_tdp_bram_array.sv | 163 ++++++++++++++++
 tb/tb_xilinx_tdp_bram_array.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xilinx_primitive_pkg.sv
// Shared sizing helpers for the BRAM primitive layer: tile geometry, bank depth
// per aspect ratio, and write-enable lane count.
package xilinx_primitive_pkg;

  localparam int MAX_TILE_WIDTH = 72;

  typedef enum logic [1:0] {
    WM_READ_FIRST,
    WM_WRITE_FIRST,
    WM_NO_CHANGE
  } write_mode_e;

  // Widest single-primitive port: x72 for a 36Kb block, x36 for an 18Kb block.
  function automatic int tile_width(input bit is_36kb);
    return is_36kb ? MAX_TILE_WIDTH : MAX_TILE_WIDTH / 2;
  endfunction

  function automatic int bram_bank_depth(input bit is_36kb, input int width);
    int d;
    if (width <= 1)       d = 32768;
    else if (width <= 2)  d = 16384;
    else if (width <= 4)  d = 8192;
    else if (width <= 9)  d = 4096;
    else if (width <= 18) d = 2048;
    else if (width <= 36) d = 1024;
    else                  d = 512;
    return is_36kb ? d : d / 2;
  endfunction

  function automatic int we_lanes(input int width, input int byte_width);
    return (width + byte_width - 1) / byte_width;
  endfunction

endpackage

// File: rtl/xilinx_tdp_bram.sv
// One depth bank: a true-dual-port RAM split into primitive-width tiles, with
// per-port output latch, WRITE_MODE behaviour and optional output register.
module xilinx_tdp_bram
  import xilinx_primitive_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    BYTE_WIDTH = 8,
  parameter int    DEPTH      = 1024,
  parameter int    TILE_WIDTH = 72,
  parameter int    DO_REG     = 1,
  parameter string WRITE_MODE = "READ_FIRST",
  localparam int   WE_W       = we_lanes(DATA_WIDTH, BYTE_WIDTH),
  localparam int   AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rsta,
  input  logic                  ena,
  input  logic                  regcea,
  input  logic [WE_W-1:0]       wea,
  input  logic [AW-1:0]         addra,
  input  logic [DATA_WIDTH-1:0] dia,
  output logic [DATA_WIDTH-1:0] doa,
  input  logic                  rstb,
  input  logic                  enb,
  input  logic                  regceb,
  input  logic [WE_W-1:0]       web,
  input  logic [AW-1:0]         addrb,
  input  logic [DATA_WIDTH-1:0] dib,
  output logic [DATA_WIDTH-1:0] dob
);

  localparam int NT = (DATA_WIDTH + TILE_WIDTH - 1) / TILE_WIDTH;
  localparam write_mode_e WM = (WRITE_MODE == "WRITE_FIRST") ? WM_WRITE_FIRST :
                               (WRITE_MODE == "NO_CHANGE")   ? WM_NO_CHANGE : WM_READ_FIRST;

  logic [DATA_WIDTH-1:0] mask_a, mask_b, lat_a, lat_b;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
      assign mask_a[gi] = wea[gi / BYTE_WIDTH];
      assign mask_b[gi] = web[gi / BYTE_WIDTH];
    end

    for (gi = 0; gi < NT; gi++) begin : g_tile
      localparam int LO = gi * TILE_WIDTH;
      localparam int W  = (DATA_WIDTH - LO < TILE_WIDTH) ? DATA_WIDTH - LO : TILE_WIDTH;

      logic [W-1:0] mem [DEPTH];
      logic [W-1:0] lat_a_reg, lat_b_reg;

      // Port B is applied last, so it wins a same-address dual write.
      always_ff @(posedge clk) begin
        for (int i = 0; i < W; i++) begin
          if (ena && mask_a[LO+i]) mem[addra][i] <= dia[LO+i];
          if (enb && mask_b[LO+i]) mem[addrb][i] <= dib[LO+i];
        end
      end

      always_ff @(posedge clk) begin
        if (rsta) begin
          lat_a_reg <= '0;
        end else if (ena) begin
          if (!(|wea) || WM == WM_READ_FIRST)
            lat_a_reg <= mem[addra];
          else if (WM == WM_WRITE_FIRST)
            lat_a_reg <= (mem[addra] & ~mask_a[LO +: W]) | (dia[LO +: W] & mask_a[LO +: W]);
        end
      end

      always_ff @(posedge clk) begin
        if (rstb) begin
          lat_b_reg <= '0;
        end else if (enb) begin
          if (!(|web) || WM == WM_READ_FIRST)
            lat_b_reg <= mem[addrb];
          else if (WM == WM_WRITE_FIRST)
            lat_b_reg <= (mem[addrb] & ~mask_b[LO +: W]) | (dib[LO +: W] & mask_b[LO +: W]);
        end
      end

      assign lat_a[LO +: W] = lat_a_reg;
      assign lat_b[LO +: W] = lat_b_reg;
    end

    if (DO_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] do_a_reg, do_b_reg;

      always_ff @(posedge clk) begin
        if (rsta)        do_a_reg <= '0;
        else if (regcea) do_a_reg <= lat_a;
        if (rstb)        do_b_reg <= '0;
        else if (regceb) do_b_reg <= lat_b;
      end

      assign doa = do_a_reg;
      assign dob = do_b_reg;
    end else begin : g_noreg
      assign doa = lat_a;
      assign dob = lat_b;
    end
  endgenerate

endmodule

// File: rtl/xilinx_tdp_bram_array.sv
// Width- and depth-tiled true-dual-port BRAM array with bank decode, read-valid
// pipeline and out-of-range protection. XILINX_TDP_BRAM_COLLISION_DET_EN adds COLL.
module xilinx_tdp_bram_array
  import xilinx_primitive_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 4096,
  parameter string BRAM_SIZE  = "36Kb",
  parameter int    DO_REG     = 1,
  parameter string WRITE_MODE = "READ_FIRST",
  parameter int    BYTE_WIDTH = 8,
  localparam int   AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int   WE_W       = we_lanes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENA,
  input  logic [WE_W-1:0]       WEA,
  input  logic [AW-1:0]         ADDRA,
  input  logic [DATA_WIDTH-1:0] DIA,
  output logic [DATA_WIDTH-1:0] DOA,
  output logic                  RDVA,
  output logic                  OORA,
  input  logic                  ENB,
  input  logic [WE_W-1:0]       WEB,
  input  logic [AW-1:0]         ADDRB,
  input  logic [DATA_WIDTH-1:0] DIB,
  output logic [DATA_WIDTH-1:0] DOB,
  output logic                  RDVB,
  output logic                  OORB
`ifdef XILINX_TDP_BRAM_COLLISION_DET_EN
  ,
  output logic                  COLL
`endif
);

  localparam bit IS_36KB    = (BRAM_SIZE == "36Kb");
  localparam int TILE_W     = tile_width(IS_36KB);
  localparam int BANK_DEPTH = bram_bank_depth(IS_36KB, (DATA_WIDTH < TILE_W) ? DATA_WIDTH : TILE_W);
  localparam int BANKS      = (DEPTH + BANK_DEPTH - 1) / BANK_DEPTH;
  localparam int SW         = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int OW         = $clog2(BANK_DEPTH);
  localparam int RD_LAT     = 1 + DO_REG;

  logic                  en        [2];
  logic [WE_W-1:0]       we        [2];
  logic [AW-1:0]         addr      [2];
  logic [DATA_WIDTH-1:0] din       [2];
  logic                  in_range  [2];
  logic                  wr        [2];
  logic [SW-1:0]         bank      [2];
  logic [OW-1:0]         offset    [2];
  logic [BANKS-1:0]      bank_en   [2];
  logic [DATA_WIDTH-1:0] bank_do   [2][BANKS];
  logic [RD_LAT-1:0]     vld_pipe_reg [2];
  logic [RD_LAT-1:0]     oor_pipe_reg [2];
  logic [SW-1:0]         sel_pipe_reg [2][RD_LAT];
  logic                  oor_reg   [2];
  logic [DATA_WIDTH-1:0] rd_data   [2];
  logic [DATA_WIDTH-1:0] hold_reg  [2];
  logic [DATA_WIDTH-1:0] dout      [2];
  logic                  suppress_b;

  assign en[0] = ENA;  assign we[0] = WEA;  assign addr[0] = ADDRA;  assign din[0] = DIA;
  assign en[1] = ENB;  assign we[1] = WEB;  assign addr[1] = ADDRB;  assign din[1] = DIB;

`ifdef XILINX_TDP_BRAM_COLLISION_DET_EN
  logic same_addr_wr;
  logic coll_reg;

  assign same_addr_wr = en[0] && en[1] && in_range[0] && in_range[1] &&
                        (addr[0] == addr[1]) && (wr[0] || wr[1]);
  // Port A wins a same-address dual write.
  assign suppress_b   = same_addr_wr && wr[0] && wr[1];

  always_ff @(posedge CLK) begin
    if (RST)               coll_reg <= 1'b0;
    else if (same_addr_wr) coll_reg <= 1'b1;
  end

  assign COLL = coll_reg;
`else
  assign suppress_b = 1'b0;
`endif

  genvar gi, gj;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [31:0] addr_ext;

      assign addr_ext     = 32'(addr[gi]);
      assign in_range[gi] = addr_ext < 32'(DEPTH);
      assign wr[gi]       = |we[gi];
      assign bank[gi]     = in_range[gi] ? SW'(addr_ext / 32'(BANK_DEPTH)) : '0;
      assign offset[gi]   = OW'(addr_ext % 32'(BANK_DEPTH));

      for (gj = 0; gj < BANKS; gj++) begin : g_en
        assign bank_en[gi][gj] = en[gi] && in_range[gi] && (bank[gi] == SW'(gj)) &&
                                 !((gi == 1) && suppress_b);
      end

      // {valid, bank, oor} travel together so the output mux sees the bank that was read.
      always_ff @(posedge CLK) begin
        if (RST) begin
          vld_pipe_reg[gi] <= '0;
          oor_pipe_reg[gi] <= '0;
          oor_reg[gi]      <= 1'b0;
          hold_reg[gi]     <= '0;
          for (int i = 0; i < RD_LAT; i++) sel_pipe_reg[gi][i] <= '0;
        end else begin
          vld_pipe_reg[gi][0] <= en[gi] && !wr[gi];
          oor_pipe_reg[gi][0] <= !in_range[gi];
          sel_pipe_reg[gi][0] <= bank[gi];
          for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_reg[gi][i] <= vld_pipe_reg[gi][i-1];
            oor_pipe_reg[gi][i] <= oor_pipe_reg[gi][i-1];
            sel_pipe_reg[gi][i] <= sel_pipe_reg[gi][i-1];
          end
          oor_reg[gi] <= en[gi] && !in_range[gi];
          if (vld_pipe_reg[gi][RD_LAT-1]) hold_reg[gi] <= rd_data[gi];
        end
      end

      assign rd_data[gi] = oor_pipe_reg[gi][RD_LAT-1] ? '0 : bank_do[gi][sel_pipe_reg[gi][RD_LAT-1]];
      assign dout[gi]    = vld_pipe_reg[gi][RD_LAT-1] ? rd_data[gi] : hold_reg[gi];
    end

    for (gi = 0; gi < BANKS; gi++) begin : g_bank
      xilinx_tdp_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .DEPTH      (BANK_DEPTH),
        .TILE_WIDTH (TILE_W),
        .DO_REG     (DO_REG),
        .WRITE_MODE (WRITE_MODE)
      ) u_bram (
        .clk    (CLK),
        .rsta   (RST),
        .ena    (bank_en[0][gi]),
        .regcea (vld_pipe_reg[0][0]),
        .wea    (we[0]),
        .addra  (offset[0]),
        .dia    (din[0]),
        .doa    (bank_do[0][gi]),
        .rstb   (RST),
        .enb    (bank_en[1][gi]),
        .regceb (vld_pipe_reg[1][0]),
        .web    (we[1]),
        .addrb  (offset[1]),
        .dib    (din[1]),
        .dob    (bank_do[1][gi])
      );
    end
  endgenerate

  assign DOA  = dout[0];
  assign RDVA = vld_pipe_reg[0][RD_LAT-1];
  assign OORA = oor_reg[0];
  assign DOB  = dout[1];
  assign RDVB = vld_pipe_reg[1][RD_LAT-1];
  assign OORB = oor_reg[1];

endmodule

// File: tb/tb_xilinx_tdp_bram_array.sv
// Directed bench for xilinx_tdp_bram_array: 3000-word x32 array, 36Kb tiles, DO_REG=1.
`timescale 1ns/1ps
module tb_xilinx_tdp_bram_array;

  localparam int DEPTH  = 3000;
  localparam int RD_LAT = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ENA, ENB;
  logic [3:0]  WEA, WEB;
  logic [11:0] ADDRA, ADDRB;
  logic [31:0] DIA, DIB, DOA, DOB;
  logic        RDVA, RDVB, OORA, OORB;
`ifdef XILINX_TDP_BRAM_COLLISION_DET_EN
  logic        COLL;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  xilinx_tdp_bram_array #(
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .BRAM_SIZE  ("36Kb"),
    .DO_REG     (1),
    .WRITE_MODE ("READ_FIRST"),
    .BYTE_WIDTH (8)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .ENA   (ENA),
    .WEA   (WEA),
    .ADDRA (ADDRA),
    .DIA   (DIA),
    .DOA   (DOA),
    .RDVA  (RDVA),
    .OORA  (OORA),
    .ENB   (ENB),
    .WEB   (WEB),
    .ADDRB (ADDRB),
    .DIB   (DIB),
    .DOB   (DOB),
    .RDVB  (RDVB),
    .OORB  (OORB)
`ifdef XILINX_TDP_BRAM_COLLISION_DET_EN
    ,
    .COLL  (COLL)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic idle();
    ENA = 1'b0; ENB = 1'b0; WEA = 4'h0; WEB = 4'h0;
  endtask

  task automatic drv_a(input logic [3:0] we, input logic [11:0] a, input logic [31:0] d);
    ENA = 1'b1; WEA = we; ADDRA = a; DIA = d;
  endtask

  task automatic drv_b(input logic [3:0] we, input logic [11:0] a, input logic [31:0] d);
    ENB = 1'b1; WEB = we; ADDRB = a; DIB = d;
  endtask

  task automatic wr(input bit port_b, input logic [11:0] a, input logic [3:0] we, input logic [31:0] d);
    $display("[TB] write %s addr=0x%03h we=%b data=0x%08h", port_b ? "B" : "A", a, we, d);
    if (port_b) drv_b(we, a, d); else drv_a(we, a, d);
    step();
    idle();
  endtask

  // Read, then confirm the valid arrives exactly RD_LAT cycles later as a one-cycle pulse with data held.
  task automatic rd_chk(input bit port_b, input logic [11:0] a, input logic [31:0] exp, input string tag);
    $display("[TB] read  %s addr=0x%03h expect=0x%08h", port_b ? "B" : "A", a, exp);
    if (port_b) drv_b(4'h0, a, 32'h0); else drv_a(4'h0, a, 32'h0);
    step();
    idle();
    check({tag, "_early"}, port_b ? RDVB : RDVA, 1'b0);
    step();
    check(tag, port_b ? {RDVB, DOB} : {RDVA, DOA}, {1'b1, exp});
    step();
    check({tag, "_hold"}, port_b ? {RDVB, DOB} : {RDVA, DOA}, {1'b0, exp});
  endtask

  initial begin
    idle();
    ADDRA = '0; ADDRB = '0; DIA = '0; DIB = '0;
    RST = 1'b1;
    // Requests during reset, including an out-of-range one, must not leak out.
    drv_a(4'h0, 12'h000, 32'h0);
    drv_b(4'h0, 12'hDAC, 32'h0);
    $display("[TB] reset 3 cycles");
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_do", {DOA, DOB}, 64'h0);
      check("rst_flags", {RDVA, RDVB, OORA, OORB}, 4'h0);
    end
    RST = 1'b0;
    idle();
    step();
    check("post_rst_flags", {RDVA, RDVB, OORA, OORB, DOA, DOB}, 64'h0);
`ifdef XILINX_TDP_BRAM_COLLISION_DET_EN
    check("coll_after_rst", COLL, 1'b0);
`endif

    // Basic write A / read B
    wr(1'b0, 12'h005, 4'hF, 32'hDEADBEEF);
    check("wr_no_rdv", RDVA, 1'b0);
    rd_chk(1'b1, 12'h005, 32'hDEADBEEF, "rd_b_005");

    // Byte enables on both ports
    wr(1'b0, 12'h020, 4'hF, 32'hFFFFFFFF);
    wr(1'b0, 12'h020, 4'b0010, 32'h0000AB00);
    rd_chk(1'b0, 12'h020, 32'hFFFFABFF, "byte_en_a");
    wr(1'b1, 12'h021, 4'hF, 32'h11223344);
    wr(1'b1, 12'h021, 4'b1001, 32'hAABBCCDD);
    rd_chk(1'b0, 12'h021, 32'hAA2233DD, "byte_en_b");

    // A writes while B reads the same address: B sees the old word
    $display("[TB] A write 0x005=0x12345678 with B read 0x005");
    drv_a(4'hF, 12'h005, 32'h12345678);
    drv_b(4'h0, 12'h005, 32'h0);
    step();
    idle();
`ifdef XILINX_TDP_BRAM_COLLISION_DET_EN
    check("coll_wr_rd", COLL, 1'b1);
`endif
    step();
    check("wr_rd_old", {RDVB, DOB}, {1'b1, 32'hDEADBEEF});
    check("wr_rd_no_rdva", RDVA, 1'b0);
    step();
    rd_chk(1'b1, 12'h005, 32'h12345678, "wr_rd_new");

    // Fill the whole array, evens on A and odds on B
    $display("[TB] burst write 0..%0d", DEPTH - 1);
    for (int k = 0; k < DEPTH / 2; k++) begin
      drv_a(4'hF, 12'(2 * k), 32'(2 * k));
      drv_b(4'hF, 12'(2 * k + 1), 32'(2 * k + 1));
      step();
    end
    idle();
    step();

    // Full-rate reads across both bank boundaries, A ascending and B descending
    $display("[TB] burst read A ascending, B descending");
    for (int k = 0; k < DEPTH + RD_LAT; k++) begin
      if (k >= RD_LAT) begin
        check("burst_a", {RDVA, DOA}, {1'b1, 32'(k - RD_LAT)});
        check("burst_b", {RDVB, DOB}, {1'b1, 32'(DEPTH - 1 - (k - RD_LAT))});
      end
      if (k < DEPTH) begin
        drv_a(4'h0, 12'(k), 32'h0);
        drv_b(4'h0, 12'(DEPTH - 1 - k), 32'h0);
      end else begin
        idle();
      end
      step();
    end
    check("burst_end", {RDVA, RDVB}, 2'b00);

    // Out-of-range read on A
    $display("[TB] read  A addr=0x%03h (out of range)", DEPTH);
    drv_a(4'h0, 12'(DEPTH), 32'h0);
    step();
    idle();
    check("oor_rd_pulse", {OORA, RDVA}, 2'b10);
    step();
    check("oor_rd_data", {OORA, RDVA, DOA}, {2'b01, 32'h0});
    step();
    check("oor_rd_clear", {OORA, RDVA}, 2'b00);

    // Out-of-range write on A must be dropped
    $display("[TB] write A addr=0x%03h (out of range)", DEPTH + 1);
    drv_a(4'hF, 12'(DEPTH + 1), 32'hCAFEF00D);
    step();
    idle();
    check("oor_wr_pulse", {OORA, RDVA}, 2'b10);
    step();
    check("oor_wr_clear", {OORA, RDVA}, 2'b00);
    rd_chk(1'b0, 12'd953, 32'd953, "oor_wr_bank0");
    rd_chk(1'b0, 12'd1977, 32'd1977, "oor_wr_bank1");
    rd_chk(1'b1, 12'd2999, 32'd2999, "last_word");

    // Out-of-range read on B at the top of the address space
    $display("[TB] read  B addr=0xfff (out of range)");
    drv_b(4'h0, 12'hFFF, 32'h0);
    step();
    idle();
    check("oorb_pulse", {OORB, RDVB}, 2'b10);
    step();
    check("oorb_data", {OORB, RDVB, DOB}, {2'b01, 32'h0});

    // Reset during a read stream
    $display("[TB] reset mid-burst");
    drv_a(4'h0, 12'd100, 32'h0);
    step();
    drv_a(4'h0, 12'd101, 32'h0);
    step();
    check("rst_mid_pre", {RDVA, DOA}, {1'b1, 32'd100});
    RST = 1'b1;
    drv_a(4'h0, 12'd102, 32'h0);
    step();
    check("rst_mid_drop", {RDVA, DOA}, 33'h0);
    RST = 1'b0;
    idle();
    step();
    check("rst_mid_flush1", {RDVA, OORA}, 2'b00);
    step();
    check("rst_mid_flush2", {RDVA, OORA, DOA}, 34'h0);
    rd_chk(1'b0, 12'd102, 32'd102, "post_rst_rd");

`ifdef XILINX_TDP_BRAM_COLLISION_DET_EN
    check("coll_cleared", COLL, 1'b0);
    $display("[TB] dual write addr 0x010 A=0x1111 B=0x2222");
    drv_a(4'hF, 12'h010, 32'h1111);
    drv_b(4'hF, 12'h010, 32'h2222);
    step();
    idle();
    check("coll_set", COLL, 1'b1);
    rd_chk(1'b0, 12'h010, 32'h1111, "coll_a_wins");
    check("coll_sticky", COLL, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
